// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses pll_reset, waits for a debounced lock, then releases sys_rst.
// Latency: lock_s lags pll_lock by 2 cycles; all outputs are registered decodes of the next state.
// Backpressure: none. Build option PLL_LOCK_CTRL_AUTO_RECOVER_EN re-sequences on lock loss instead of failing.
module pll_lock_ctrl #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 270000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    // The WAIT_LOCK cycle that first sees lock_s=1 counts toward the stable window.
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'((LOCK_STABLE_CYCLES > 1) ? LOCK_STABLE_CYCLES - 2 : 0);
    localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       retry_nxt;
    logic [7:0]       loss_nxt;
    logic [1:0]       rst_sync;
    logic             srst;
    logic [1:0]       lock_sync;
    logic             lock_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end

    assign srst = rst_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_sync <= 2'b00;
        end else begin
            lock_sync <= {lock_sync[0], pll_lock};
        end
    end

    assign lock_s = lock_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_PLL_RST;
        end else if (srst) begin
            state <= S_PLL_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        loss_nxt  = lock_loss_cnt;
        case (state)
            S_PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_nxt = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (lock_s) begin
                    if (LOCK_STABLE_CYCLES > 1) begin
                        state_nxt = S_STABLE;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_cnt < RETRY_MAX) begin
                        retry_nxt = retry_cnt + 3'd1;
                        state_nxt = S_PLL_RST;
                    end else begin
                        state_nxt = S_FAIL;
                    end
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    if (lock_loss_cnt != 8'hFF) begin
                        loss_nxt = lock_loss_cnt + 8'd1;
                    end
`ifdef PLL_LOCK_CTRL_AUTO_RECOVER_EN
                    retry_nxt = 3'd0;
                    state_nxt = S_PLL_RST;
`else
                    state_nxt = S_FAIL;
`endif
                end
            end
            S_FAIL: begin
                state_nxt = S_FAIL;
            end
            default: begin
                state_nxt = S_FAIL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            pll_reset     <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            fail          <= 1'b0;
            retry_cnt     <= 3'd0;
            lock_loss_cnt <= 8'd0;
        end else if (srst) begin
            cnt           <= '0;
            pll_reset     <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            fail          <= 1'b0;
            retry_cnt     <= 3'd0;
            lock_loss_cnt <= 8'd0;
        end else begin
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            // Decoding the next state keeps these glitch-free and aligned with the state change.
            pll_reset     <= (state_nxt == S_PLL_RST) || (state_nxt == S_FAIL);
            sys_rst       <= (state_nxt != S_RUN);
            ready         <= (state_nxt == S_RUN);
            fail          <= (state_nxt == S_FAIL);
            retry_cnt     <= retry_nxt;
            lock_loss_cnt <= loss_nxt;
        end
    end

endmodule
